// File: rtl/seq_link_pkg.sv
// Shared definitions for the serial sequence-detector link:
// frame states and the default sync pattern used by transmitter and detector.
package seq_link_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SYNC = 2'd1,
      ST_DATA = 2'd2,
      ST_GAP  = 2'd3
   } link_state_e;

   localparam int SYNC_W_DEFAULT = 4;
   localparam logic [SYNC_W_DEFAULT-1:0] SYNC_DEFAULT = 4'b1011;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/seq_frame_tx_piso_shift.sv
// Parallel-in/serial-out register: loads a word, shifts left, exposes the MSB.
module piso_shift #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              i_load,
   input  logic              i_shift,
   input  logic [DATA_W-1:0] i_data,
   output logic              o_msb
);

   logic [DATA_W-1:0] r_data;

   always_ff @(posedge clk) begin
      if (i_load) begin
         r_data <= i_data;
      end else if (i_shift) begin
         r_data <= r_data << 1;
      end
   end

   assign o_msb = r_data[DATA_W-1];

endmodule

// File: rtl/seq_frame_tx.sv
// Serial frame transmitter: sync pattern, then payload MSB-first, then idle zeros,
// with a valid/ready word interface and registered serial outputs.
module seq_frame_tx
   import seq_link_pkg::*;
#(
   parameter int                DATA_W  = 8,
   parameter int                SYNC_W  = SYNC_W_DEFAULT,
   parameter logic [SYNC_W-1:0] SYNC    = SYNC_W'(SYNC_DEFAULT),
   parameter int                GAP_LEN = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              s,
   output logic              busy,
   output logic              done
);

   localparam int CNT_MAX = max3(SYNC_W, DATA_W, GAP_LEN);
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_W - 1);
   localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   localparam logic [1:0] S_IDLE = ST_IDLE;
   localparam logic [1:0] S_SYNC = ST_SYNC;
   localparam logic [1:0] S_DATA = ST_DATA;
   localparam logic [1:0] S_GAP  = ST_GAP;

   logic [1:0]        r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic [SYNC_W-1:0] r_sync;
   logic              r_s;
   logic              r_busy;
   logic              r_done;
   logic              r_in_ready;

   logic w_accept;
   logic w_shift;
   logic w_msb;

   assign w_accept = in_valid && r_in_ready;

   // The payload register advances on every edge that puts a new payload bit on s.
   assign w_shift = ((r_state == S_SYNC) && (r_cnt == '0)) ||
                    ((r_state == S_DATA) && (r_cnt != '0));

   piso_shift #(
      .DATA_W (DATA_W)
   ) u_piso (
      .clk     (clk),
      .i_load  (w_accept),
      .i_shift (w_shift),
      .i_data  (in_data),
      .o_msb   (w_msb)
   );

   // Sync bits after the first one, already aligned so the next bit is the MSB.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_sync <= SYNC << 1;
      end else if (r_state == S_SYNC) begin
         r_sync <= r_sync << 1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_s        <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_in_ready <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_s    <= 1'b0;
               r_busy <= 1'b0;
               if (w_accept) begin
                  r_state    <= S_SYNC;
                  r_cnt      <= SYNC_LAST;
                  r_s        <= SYNC[SYNC_W-1];
                  r_busy     <= 1'b1;
                  r_in_ready <= 1'b0;
               end else begin
                  r_in_ready <= 1'b1;
               end
            end
            S_SYNC: begin
               if (r_cnt == '0) begin
                  r_state <= S_DATA;
                  r_cnt   <= DATA_LAST;
                  r_s     <= w_msb;
                  r_done  <= (DATA_W == 1);
               end else begin
                  r_cnt <= r_cnt - CNT_ONE;
                  r_s   <= r_sync[SYNC_W-1];
               end
            end
            S_DATA: begin
               if (r_cnt == '0) begin
                  r_s <= 1'b0;
                  if (GAP_LEN == 0) begin
                     r_state    <= S_IDLE;
                     r_cnt      <= '0;
                     r_busy     <= 1'b0;
                     r_in_ready <= 1'b1;
                  end else begin
                     r_state <= S_GAP;
                     r_cnt   <= GAP_LAST;
                  end
               end else begin
                  r_cnt  <= r_cnt - CNT_ONE;
                  r_s    <= w_msb;
                  r_done <= (r_cnt == CNT_ONE);
               end
            end
            S_GAP: begin
               r_s <= 1'b0;
               if (r_cnt == '0) begin
                  r_state    <= S_IDLE;
                  r_busy     <= 1'b0;
                  r_in_ready <= 1'b1;
               end else begin
                  r_cnt <= r_cnt - CNT_ONE;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_cnt   <= '0;
               r_s     <= 1'b0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready = r_in_ready;
   assign s        = r_s;
   assign busy     = r_busy;
   assign done     = r_done;

endmodule
